riscv_decoder_seq: RTL and testbench
====================================

// Module: riscv_decoder_seq
// PURPOSE
//  Sequential main decoder for the RV32I core. Latches one instruction, decodes all base opcodes, and drives datapath controls.
//  Stalls PC/regfile writes across a variable-latency data-memory handshake. Traps on illegal instructions and memory timeouts.
//  Sits between instruction fetch (valid/ready) and the datapath muxes, ALU, regfile and LSU.
// PARAMETERS
//  MEM_TIMEOUT  15  max MEM-state cycles without mem_ready before a trap; 0 = never time out
//  ILL_HALT     1   1: illegal instr -> TRAP (sticky); 0: skip it (enpc pulse, no writes), continue
// PORTS
//  Clocking: one clock. Reset is synchronous and active-high.
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  instr_valid  in   1   fetch has an instruction on instr
//  instr        in   32  instruction word: opcode=[6:0], func3=[14:12], func7=[31:25]
//  instr_ready  out  1   decoder can accept; transfer when instr_valid&instr_ready
//  mem_ready    in   1   data memory completes the current access this cycle
//  mem_req      out  1   data memory access in progress
//  srcA         out  2   0 rs1, 1 pc, 2 zero
//  srcB         out  3   0 rs2, 1 imm_I, 2 imm_U, 3 imm_S, 4 const 4
//  aop          out  5   ALU op: {func7[6:5],func3}; branches {2'b11,func3}
//  memi         out  5   {access, write, func3 size/sign}
//  mwe          out  1   memory write enable (stores only)
//  ws           out  1   writeback select: 0 ALU, 1 memory
//  rfwe/enpc    out  1   regfile write / PC advance; high only on the completion cycle
//  b/jal/jalr   out  1   branch / jal / jalr instruction
//  ill_instr    out  1   illegal instruction (sticky in TRAP; 1-cycle pulse if ILL_HALT=0)
//  mem_err      out  1   memory timeout, sticky until rst
// BEHAVIOUR
//  IR latches instr on transfer. Controls are decoded combinationally from IR and gated by state.
//  Reset: state=IDLE, IR=0x00000013, counter=0. Every output is 0 except instr_ready=1.
//  States and transitions:
//   IDLE  all controls 0, instr_ready=1. Transfer -> EXEC (non-mem), MEM (load/store) or TRAP (illegal, ILL_HALT=1).
//   EXEC  controls valid, enpc=1, rfwe per type, instr_ready=1. Back-to-back transfer -> next state by type; else -> IDLE.
//   MEM   mem_req=1, memi/mwe/ws valid, enpc=rfwe=0, instr_ready=0, counter++.
//         On mem_ready: enpc=1, rfwe=load, instr_ready=1, counter cleared. Next state by type if a transfer happens, else IDLE.
//         Counter==MEM_TIMEOUT without mem_ready -> TRAP with mem_err=1.
//   TRAP  all strobes 0, instr_ready=0. Only rst exits.
//  Decode (anything unlisted is 0):
//   R  0110011: srcA0 srcB0 aop={f7[6:5],f3} rfwe. Legal func7: 0x00, or 0x20 with f3 in {0,5}.
//   I  0010011: srcB1 aop={1'b0,f3==5&f7[5],f3} rfwe
//   LD 0000011: srcB1 ws1 memi={1,0,f3}; f3 in {3,6,7} is illegal
//   ST 0100011: srcB3 memi={1,1,f3} mwe; f3>2 is illegal
//   BR 1100011: srcB0 aop={2'b11,f3} b; f3 in {2,3} is illegal
//   JAL 1101111: jal srcA1 srcB4 rfwe. JALR 1100111: jalr srcA1 srcB4 rfwe; f3!=0 is illegal.
//   LUI 0110111: srcA2 srcB2 rfwe. AUIPC 0010111: srcA1 srcB2 rfwe.
//   Other opcodes, or instr[1:0]!=2'b11: illegal.
//  Boundary conditions:
//   mem_ready in the first MEM cycle gives single-cycle completion.
//   mem_ready outside MEM is ignored.
//   rst mid-MEM aborts the access: mem_req=0 on the next cycle.
//   Counter width is $clog2(MEM_TIMEOUT+1).
// CONFIGURATION
//  DECODER_MEXT_EN defined: R-type func7=0000001 is legal (M extension), aop={2'b10,f3}, rfwe.
//  DECODER_MEXT_EN undefined: func7=0000001 is illegal.
// STRUCTURE
//  decoder_pkg: opcode constants, SRCA_*/SRCB_* encodings, AOP_BR/AOP_M prefixes, state encodings.
//  Sub-module decoder_comb: pure combinational IR -> control bundle + illegal flag. The top holds the FSM, IR and counter.
// TESTING
//  1. Reset, then addi 0x00500093 -> next cycle EXEC: srcB=1, aop=0, rfwe=1, enpc=1. Then IDLE, all 0.
//  2. lw 0x0000A103, mem_ready after 3 cycles -> mem_req=1 for 3 cycles with enpc=rfwe=0; completion cycle enpc=1, rfwe=1, ws=1, memi=5'b10010.
//  3. sw 0x0020A023, mem_ready held high -> one MEM cycle: mwe=1, memi=5'b11010, rfwe=0, enpc=1.
//  4. lw with mem_ready never asserted -> mem_err=1 after 15 MEM cycles; TRAP until rst, instr_ready=0.
//  5. instr 0xFFFFFFFF with ILL_HALT=1 -> ill_instr=1 sticky. With ILL_HALT=0 -> one cycle enpc=1, ill_instr=1, rfwe=0.
//  6. mul 0x02208033 -> aop=5'b10000, rfwe=1 with DECODER_MEXT_EN; ill_instr=1 without it.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants, types and legality check for the RV32I sequential decoder.
// Optional M-extension decode is enabled by defining DECODER_MEXT_EN.
package decoder_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_PC   = 2'd1;
    localparam logic [1:0] SRCA_ZERO = 2'd2;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IMMI = 3'd1;
    localparam logic [2:0] SRCB_IMMU = 3'd2;
    localparam logic [2:0] SRCB_IMMS = 3'd3;
    localparam logic [2:0] SRCB_FOUR = 3'd4;

    localparam logic [1:0] AOP_BR = 2'b11;
    localparam logic [1:0] AOP_M  = 2'b10;

`ifdef DECODER_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM,
        ST_TRAP
    } state_t;

    typedef struct packed {
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [4:0] aop;
        logic [4:0] memi;
        logic       mwe;
        logic       ws;
        logic       rfwe;
        logic       b;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

    function automatic logic is_illegal(
        input logic [6:0] op,
        input logic [2:0] f3,
        input logic [6:0] f7
    );
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            (op == OP_R):
                bad = !((f7 == 7'h00)
                     || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                     || (MEXT && f7 == 7'h01));
            (op == OP_I), (op == OP_JAL),
            (op == OP_LUI), (op == OP_AUIPC):
                bad = 1'b0;
            (op == OP_LD):
                bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            (op == OP_ST):
                bad = (f3 > 3'd2);
            (op == OP_BR):
                bad = (f3 == 3'd2) || (f3 == 3'd3);
            (op == OP_JALR):
                bad = (f3 != 3'd0);
            default:
                bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/decoder_comb.sv
// Pure combinational decode of the instruction register into a control bundle.
// Ports: ir (32b instruction) -> ctrl (ctrl_t bundle), illegal (1b). DECODER_MEXT_EN adds MUL/DIV.
module decoder_comb (
    input  logic [31:0]              ir,
    output decoder_pkg::ctrl_t       ctrl,
    output logic                     illegal
);
    import decoder_pkg::*;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_ir;

    assign op        = ir[6:0];
    assign f3        = ir[14:12];
    assign f7        = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};
    assign illegal   = is_illegal(op, f3, f7);

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            (op == OP_R): begin
                ctrl.rfwe = 1'b1;
                ctrl.aop  = (MEXT && f7 == 7'h01)
                          ? {AOP_M, f3} : {f7[6:5], f3};
            end
            (op == OP_I): begin
                ctrl.srcb = SRCB_IMMI;
                ctrl.aop  = {1'b0, (f3 == 3'd5) & f7[5], f3};
                ctrl.rfwe = 1'b1;
            end
            (op == OP_LD): begin
                ctrl.srcb = SRCB_IMMI;
                ctrl.ws   = 1'b1;
                ctrl.memi = {2'b10, f3};
            end
            (op == OP_ST): begin
                ctrl.srcb = SRCB_IMMS;
                ctrl.memi = {2'b11, f3};
                ctrl.mwe  = 1'b1;
            end
            (op == OP_BR): begin
                ctrl.srcb = SRCB_RS2;
                ctrl.aop  = {AOP_BR, f3};
                ctrl.b    = 1'b1;
            end
            (op == OP_JAL): begin
                ctrl.jal  = 1'b1;
                ctrl.srca = SRCA_PC;
                ctrl.srcb = SRCB_FOUR;
                ctrl.rfwe = 1'b1;
            end
            (op == OP_JALR): begin
                ctrl.jalr = 1'b1;
                ctrl.srca = SRCA_PC;
                ctrl.srcb = SRCB_FOUR;
                ctrl.rfwe = 1'b1;
            end
            (op == OP_LUI): begin
                ctrl.srca = SRCA_ZERO;
                ctrl.srcb = SRCB_IMMU;
                ctrl.rfwe = 1'b1;
            end
            (op == OP_AUIPC): begin
                ctrl.srca = SRCA_PC;
                ctrl.srcb = SRCB_IMMU;
                ctrl.rfwe = 1'b1;
            end
            default: ;
        endcase
        // An illegal word must not leak any datapath control.
        if (illegal) ctrl = '0;
    end

endmodule

// File: rtl/riscv_decoder_seq.sv
// Sequential RV32I main decoder: IR, IDLE/EXEC/MEM/TRAP FSM, memory timeout counter.
// Ports: clk, rst (sync, high); fetch instr_valid/instr/instr_ready; LSU mem_ready/mem_req;
// datapath srcA, srcB, aop, memi, mwe, ws, rfwe, enpc, b, jal, jalr; traps ill_instr, mem_err.
// Build macro DECODER_MEXT_EN enables M-extension R-type decode.
module riscv_decoder_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter bit ILL_HALT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic [1:0]  srcA,
    output logic [2:0]  srcB,
    output logic [4:0]  aop,
    output logic [4:0]  memi,
    output logic        mwe,
    output logic        ws,
    output logic        rfwe,
    output logic        enpc,
    output logic        b,
    output logic        jal,
    output logic        jalr,
    output logic        ill_instr,
    output logic        mem_err
);
    import decoder_pkg::*;

    // Zero timeout still needs a one-bit counter to keep widths legal.
    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state, state_nxt, acc;
    logic [31:0]   ir;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          ill_flag, ill_nxt;
    logic          err_flag, err_nxt;
    logic          xfer, tmo;
    ctrl_t         ctrl;
    logic          illegal;

    decoder_comb u_dec (
        .ir      (ir),
        .ctrl    (ctrl),
        .illegal (illegal)
    );

    assign xfer = instr_valid & instr_ready;
    assign tmo  = (MEM_TIMEOUT != 0) && (cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            ir       <= 32'h0000_0013;
            cnt      <= '0;
            ill_flag <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ill_flag <= ill_nxt;
            err_flag <= err_nxt;
            if (xfer) ir <= instr;
        end
    end

    always_comb begin
        // Destination for an instruction arriving this cycle.
        if (is_illegal(instr[6:0], instr[14:12], instr[31:25]))
            acc = ILL_HALT ? ST_TRAP : ST_EXEC;
        else if (is_mem(instr[6:0]))
            acc = ST_MEM;
        else
            acc = ST_EXEC;

        state_nxt = state;
        cnt_nxt   = cnt;
        ill_nxt   = ill_flag;
        err_nxt   = err_flag;
        unique case (state)
            ST_IDLE, ST_EXEC: begin
                state_nxt = xfer ? acc : ST_IDLE;
            end
            ST_MEM: begin
                if (mem_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = xfer ? acc : ST_IDLE;
                end else if (tmo) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_TRAP;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_TRAP: ;
        endcase
        if (xfer && acc == ST_TRAP) ill_nxt = 1'b1;
    end

    always_comb begin
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        srcA        = '0;
        srcB        = '0;
        aop         = '0;
        memi        = '0;
        mwe         = 1'b0;
        ws          = 1'b0;
        rfwe        = 1'b0;
        enpc        = 1'b0;
        b           = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        ill_instr   = 1'b0;
        mem_err     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
            end
            ST_EXEC: begin
                instr_ready = 1'b1;
                srcA        = ctrl.srca;
                srcB        = ctrl.srcb;
                aop         = ctrl.aop;
                memi        = ctrl.memi;
                mwe         = ctrl.mwe;
                ws          = ctrl.ws;
                rfwe        = ctrl.rfwe;
                enpc        = 1'b1;
                b           = ctrl.b;
                jal         = ctrl.jal;
                jalr        = ctrl.jalr;
                ill_instr   = illegal;
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                instr_ready = mem_ready;
                srcA        = ctrl.srca;
                srcB        = ctrl.srcb;
                aop         = ctrl.aop;
                memi        = ctrl.memi;
                mwe         = ctrl.mwe;
                ws          = ctrl.ws;
                enpc        = mem_ready;
                // ws marks a load: only loads write the regfile.
                rfwe        = mem_ready & ctrl.ws;
            end
            ST_TRAP: begin
                ill_instr = ill_flag;
                mem_err   = err_flag;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_decoder_seq.sv
// Self-checking bench for riscv_decoder_seq: directed scenarios plus randomized
// traffic against an instruction-level reference model (ILL_HALT=0 instance).
module tb_riscv_decoder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        mem_ready;

    logic       h_rdy, h_mreq, h_mwe, h_ws, h_rfwe, h_enpc;
    logic       h_b, h_jal, h_jalr, h_ill, h_merr;
    logic [1:0] h_sa;
    logic [2:0] h_sb;
    logic [4:0] h_aop, h_mi;
    logic       s_rdy, s_mreq, s_mwe, s_ws, s_rfwe, s_enpc;
    logic       s_b, s_jal, s_jalr, s_ill, s_merr;
    logic [1:0] s_sa;
    logic [2:0] s_sb;
    logic [4:0] s_aop, s_mi;

    logic [25:0] vh, vs;
    int nvec = 0;
    int nerr = 0;

    localparam logic [25:0] V_IDLE = 26'h2000000;
    localparam logic [25:0] V_TILL = 26'h0000002;
    localparam logic [25:0] V_TERR = 26'h0000001;
    localparam logic [25:0] V_SKIP = 26'h2000022;

    riscv_decoder_seq #(.MEM_TIMEOUT(15), .ILL_HALT(1'b1)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(h_rdy), .mem_ready(mem_ready), .mem_req(h_mreq),
        .srcA(h_sa), .srcB(h_sb), .aop(h_aop), .memi(h_mi), .mwe(h_mwe),
        .ws(h_ws), .rfwe(h_rfwe), .enpc(h_enpc), .b(h_b), .jal(h_jal),
        .jalr(h_jalr), .ill_instr(h_ill), .mem_err(h_merr)
    );

    riscv_decoder_seq #(.MEM_TIMEOUT(15), .ILL_HALT(1'b0)) dut_skip (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(s_rdy), .mem_ready(mem_ready), .mem_req(s_mreq),
        .srcA(s_sa), .srcB(s_sb), .aop(s_aop), .memi(s_mi), .mwe(s_mwe),
        .ws(s_ws), .rfwe(s_rfwe), .enpc(s_enpc), .b(s_b), .jal(s_jal),
        .jalr(s_jalr), .ill_instr(s_ill), .mem_err(s_merr)
    );

    assign vh = {h_rdy, h_mreq, h_sa, h_sb, h_aop, h_mi, h_mwe, h_ws,
                 h_rfwe, h_enpc, h_b, h_jal, h_jalr, h_ill, h_merr};
    assign vs = {s_rdy, s_mreq, s_sa, s_sb, s_aop, s_mi, s_mwe, s_ws,
                 s_rfwe, s_enpc, s_b, s_jal, s_jalr, s_ill, s_merr};

    always #5 clk = ~clk;

    // Output vector: rdy mreq srcA srcB aop memi mwe ws rfwe enpc b jal jalr ill merr
    function automatic logic [25:0] ev(
        input logic rdy, input logic mreq, input logic [1:0] sa,
        input logic [2:0] sb, input logic [4:0] a, input logic [4:0] mi,
        input logic mw, input logic w, input logic rf, input logic pc,
        input logic br, input logic j, input logic jr
    );
        return {rdy, mreq, sa, sb, a, mi, mw, w, rf, pc, br, j, jr, 2'b00};
    endfunction

    typedef struct packed {
        logic       legal;
        logic [1:0] sa;
        logic [2:0] sb;
        logic [4:0] aop;
        logic [4:0] mi;
        logic       mwe;
        logic       ws;
        logic       rf;
        logic       br;
        logic       jal;
        logic       jalr;
    } ref_t;

    // Reference decode written straight from the opcode table.
    function automatic ref_t ref_dec(input logic [31:0] w);
        ref_t r;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit mext;
`ifdef DECODER_MEXT_EN
        mext = 1'b1;
`else
        mext = 1'b0;
`endif
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        r = '0;
        r.legal = 1'b1;
        if (op == 7'b0110011) begin
            r.rf = 1'b1;
            if (f7 == 7'h00) r.aop = {2'b00, f3};
            else if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) r.aop = {2'b01, f3};
            else if (f7 == 7'h01 && mext) r.aop = {2'b10, f3};
            else r.legal = 1'b0;
        end else if (op == 7'b0010011) begin
            r.sb = 3'd1;
            r.aop = {1'b0, f3 == 3'd5 && f7[5], f3};
            r.rf = 1'b1;
        end else if (op == 7'b0000011) begin
            r.sb = 3'd1;
            r.ws = 1'b1;
            r.mi = {2'b10, f3};
            if (f3 == 3 || f3 == 6 || f3 == 7) r.legal = 1'b0;
        end else if (op == 7'b0100011) begin
            r.sb = 3'd3;
            r.mi = {2'b11, f3};
            r.mwe = 1'b1;
            if (f3 > 2) r.legal = 1'b0;
        end else if (op == 7'b1100011) begin
            r.aop = {2'b11, f3};
            r.br = 1'b1;
            if (f3 == 2 || f3 == 3) r.legal = 1'b0;
        end else if (op == 7'b1101111) begin
            r.jal = 1'b1; r.sa = 2'd1; r.sb = 3'd4; r.rf = 1'b1;
        end else if (op == 7'b1100111) begin
            r.jalr = 1'b1; r.sa = 2'd1; r.sb = 3'd4; r.rf = 1'b1;
            if (f3 != 0) r.legal = 1'b0;
        end else if (op == 7'b0110111) begin
            r.sa = 2'd2; r.sb = 3'd2; r.rf = 1'b1;
        end else if (op == 7'b0010111) begin
            r.sa = 2'd1; r.sb = 3'd2; r.rf = 1'b1;
        end else begin
            r.legal = 1'b0;
        end
        if (!r.legal) r = '0;
        return r;
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        w = $urandom;
        case ($urandom % 11)
            0: begin
                w[6:0] = 7'b0110011;
                case ($urandom % 4)
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b1100011;
            5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;
            7: w[6:0] = 7'b0110111;
            8: w[6:0] = 7'b0010111;
            9: begin w[6:0] = 7'b1100111; w[14:12] = 3'd0; end
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0; instr = '0;
        @(negedge clk); @(negedge clk); #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL reset_halt: got %h want %h", vh, V_IDLE);
        end
        nvec++;
        if (vs !== V_IDLE) begin
            nerr++; $display("FAIL reset_skip: got %h want %h", vs, V_IDLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        logic [25:0] e;
        @(negedge clk); instr_valid = 1'b1; instr = 32'h00500093; #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL addi_idle_pre: got %h want %h", vh, V_IDLE);
        end
        @(negedge clk); instr_valid = 1'b0; #1;
        e = ev(1'b1, 1'b0, 2'd0, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (vh !== e) begin
            nerr++; $display("FAIL addi_exec: got %h want %h", vh, e);
        end
        @(negedge clk); #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL addi_idle_post: got %h want %h", vh, V_IDLE);
        end
    endtask

    task automatic test_load_wait();
        logic [25:0] e;
        @(negedge clk); instr_valid = 1'b1; instr = 32'h0000A103;
        mem_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0;
        e = ev(1'b0, 1'b1, 2'd0, 3'd1, 5'd0, 5'b10010, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            nvec++;
            if (vh !== e) begin
                nerr++; $display("FAIL lw_wait%0d: got %h want %h", k, vh, e);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        e = ev(1'b1, 1'b1, 2'd0, 3'd1, 5'd0, 5'b10010, 1'b0, 1'b1,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (vh !== e) begin
            nerr++; $display("FAIL lw_done: got %h want %h", vh, e);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL lw_idle: got %h want %h", vh, V_IDLE);
        end
    endtask

    task automatic test_store();
        logic [25:0] e;
        @(negedge clk); instr_valid = 1'b1; instr = 32'h0020A023;
        mem_ready = 1'b1; #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL sw_idle_memrdy: got %h want %h", vh, V_IDLE);
        end
        @(negedge clk); instr_valid = 1'b0; #1;
        e = ev(1'b1, 1'b1, 2'd0, 3'd3, 5'd0, 5'b11010, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (vh !== e) begin
            nerr++; $display("FAIL sw_mem: got %h want %h", vh, e);
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL sw_idle: got %h want %h", vh, V_IDLE);
        end
    endtask

    task automatic test_timeout();
        logic [25:0] e;
        @(negedge clk); instr_valid = 1'b1; instr = 32'h0000A103;
        mem_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0;
        e = ev(1'b0, 1'b1, 2'd0, 3'd1, 5'd0, 5'b10010, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            #1;
            nvec++;
            if (vh !== e) begin
                nerr++; $display("FAIL tmo_wait%0d: got %h want %h", k, vh, e);
            end
            @(negedge clk);
        end
        #1;
        nvec++;
        if (vh !== V_TERR) begin
            nerr++; $display("FAIL tmo_trap: got %h want %h", vh, V_TERR);
        end
        instr_valid = 1'b1; instr = 32'h00500093; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if (vh !== V_TERR) begin
            nerr++; $display("FAIL tmo_sticky: got %h want %h", vh, V_TERR);
        end
        nvec++;
        if (vs !== V_TERR) begin
            nerr++; $display("FAIL tmo_skip: got %h want %h", vs, V_TERR);
        end
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        @(negedge clk); instr_valid = 1'b1; instr = 32'h0000A103;
        mem_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0; #1;
        nvec++;
        if (h_mreq !== 1'b1) begin
            nerr++; $display("FAIL abort_pre: got %b want 1", h_mreq);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        nvec++;
        if (vh !== V_IDLE) begin
            nerr++; $display("FAIL abort_rst: got %h want %h", vh, V_IDLE);
        end
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        logic [25:0] e;
        @(negedge clk); instr_valid = 1'b1; instr = 32'hFFFFFFFF;
        @(negedge clk); instr_valid = 1'b0; #1;
        nvec++;
        if (vh !== V_TILL) begin
            nerr++; $display("FAIL ill_halt: got %h want %h", vh, V_TILL);
        end
        nvec++;
        if (vs !== V_SKIP) begin
            nerr++; $display("FAIL ill_skip: got %h want %h", vs, V_SKIP);
        end
        @(negedge clk); instr_valid = 1'b1; instr = 32'h00500093; #1;
        nvec++;
        if (vs !== V_IDLE) begin
            nerr++; $display("FAIL ill_skip_idle: got %h want %h", vs, V_IDLE);
        end
        @(negedge clk); instr_valid = 1'b0; #1;
        e = ev(1'b1, 1'b0, 2'd0, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nvec++;
        if (vs !== e) begin
            nerr++; $display("FAIL ill_skip_cont: got %h want %h", vs, e);
        end
        nvec++;
        if (vh !== V_TILL) begin
            nerr++; $display("FAIL ill_sticky: got %h want %h", vh, V_TILL);
        end
        test_reset();
    endtask

    task automatic test_mext();
        logic [25:0] eh, es;
        @(negedge clk); instr_valid = 1'b1; instr = 32'h02208033;
        @(negedge clk); instr_valid = 1'b0; #1;
`ifdef DECODER_MEXT_EN
        eh = ev(1'b1, 1'b0, 2'd0, 3'd0, 5'b10000, 5'd0, 1'b0, 1'b0,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        es = eh;
`else
        eh = V_TILL;
        es = V_SKIP;
`endif
        nvec++;
        if (vh !== eh) begin
            nerr++; $display("FAIL mul_halt: got %h want %h", vh, eh);
        end
        nvec++;
        if (vs !== es) begin
            nerr++; $display("FAIL mul_skip: got %h want %h", vs, es);
        end
        test_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [7];
        logic [25:0] exp [7];
        seq = '{32'h00500093, 32'h402081b3, 32'h00208463, 32'h0080006F,
                32'h123450b7, 32'h00001097, 32'h000080e7};
        exp[0] = ev(1'b1, 1'b0, 2'd0, 3'd1, 5'd0, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[1] = ev(1'b1, 1'b0, 2'd0, 3'd0, 5'b01000, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[2] = ev(1'b1, 1'b0, 2'd0, 3'd0, 5'b11000, 5'd0, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        exp[3] = ev(1'b1, 1'b0, 2'd1, 3'd4, 5'd0, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        exp[4] = ev(1'b1, 1'b0, 2'd2, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[5] = ev(1'b1, 1'b0, 2'd1, 3'd2, 5'd0, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp[6] = ev(1'b1, 1'b0, 2'd1, 3'd4, 5'd0, 5'd0, 1'b0, 1'b0,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); instr_valid = 1'b1; instr = seq[i]; #1;
            if (i > 0) begin
                nvec++;
                if (vh !== exp[i-1]) begin
                    nerr++;
                    $display("FAIL b2b%0d: got %h want %h", i - 1, vh, exp[i-1]);
                end
            end
        end
        @(negedge clk); instr_valid = 1'b0; #1;
        nvec++;
        if (vh !== exp[6]) begin
            nerr++; $display("FAIL b2b6: got %h want %h", vh, exp[6]);
        end
        @(negedge clk); #1;
    endtask

    // Random traffic on the skip-mode instance, modelled per instruction.
    task automatic test_random();
        int          ph;
        int          waits;
        logic [31:0] cur;
        ref_t        d, dn;
        logic [25:0] e;
        test_reset();
        ph = 0; waits = 0; cur = 32'h00000013;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            instr_valid = ($urandom % 4) != 0;
            instr       = gen();
            mem_ready   = ($urandom % 3) != 0;
            #1;
            d = ref_dec(cur);
            case (ph)
                0: e = V_IDLE;
                1: e = d.legal
                     ? ev(1'b1, 1'b0, d.sa, d.sb, d.aop, d.mi, d.mwe, d.ws,
                          d.rf, 1'b1, d.br, d.jal, d.jalr)
                     : V_SKIP;
                2: e = ev(mem_ready, 1'b1, d.sa, d.sb, d.aop, d.mi, d.mwe,
                          d.ws, mem_ready & d.ws, mem_ready,
                          1'b0, 1'b0, 1'b0);
                default: e = V_TERR;
            endcase
            nvec++;
            if (vs !== e) begin
                nerr++;
                $display("FAIL rand%0d ir=%h: got %h want %h", n, cur, vs, e);
            end
            if (ph == 2 && !mem_ready) begin
                waits++;
                if (waits == 15) ph = 3;
            end else if (ph != 3) begin
                if (instr_valid && e[25]) begin
                    cur = instr;
                    dn  = ref_dec(instr);
                    if (dn.legal && dn.mi[4]) begin
                        ph = 2; waits = 0;
                    end else begin
                        ph = 1;
                    end
                end else begin
                    ph = 0;
                end
            end
        end
        instr_valid = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_addi();
        test_load_wait();
        test_store();
        test_timeout();
        test_reset_mid_mem();
        test_illegal();
        test_mext();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
